// File: rtl/gf2mz_cyclic_mul_if.sv
// Load/read/control bundle of the cyclic GF(2^M)[z] multiplier.
// master = the driving datapath, slave = the multiplier engine.
interface gf2mz_cyclic_mul_if #(
    parameter int N = 47,
    parameter int M = 79
) ();
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic          ld_we;
    logic          ld_sel;
    logic [AW-1:0] ld_addr;
    logic [M-1:0]  ld_data;
    logic [AW-1:0] rd_addr;
    logic [M-1:0]  rd_data;
    logic          busy;
    logic          done;

    modport master (
        output start, ld_we, ld_sel, ld_addr, ld_data, rd_addr,
        input  rd_data, busy, done
    );

    modport slave (
        input  start, ld_we, ld_sel, ld_addr, ld_data, rd_addr,
        output rd_data, busy, done
    );
endinterface

// File: rtl/gf2mz_cyclic_mul.sv
// C(z) = A(z)*B(z) mod (z^N - 1) over GF(2^M) with field polynomial x^M + x^K + 1, D lanes.
// Define GF2MZ_PIPE_EN to split each lane into partial-product and reduction stages (L = 2).
module gf2mz_cyclic_mul #(
    parameter int N = 47,
    parameter int M = 79,
    parameter int K = 9,
    parameter int D = 5
) (
    input  logic              clk,
    input  logic              rst_b,
    gf2mz_cyclic_mul_if.slave bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int W  = (N + D - 1) / D;
    localparam int WW = (W > 1) ? $clog2(W) : 1;
    localparam int JW = $clog2(2 * N + D) + 1;
`ifdef GF2MZ_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [AW:0]   N_EXT      = (AW + 1)'(N);
    localparam logic [JW-1:0] N_J        = JW'(N);
    localparam logic [AW-1:0] I_LAST     = AW'(N - 1);
    localparam logic [WW-1:0] W_LAST     = WW'(W - 1);
    localparam logic [1:0]    DRAIN_LOAD = 2'(LAT);

    // state   | meaning
    // S_IDLE  | operand loads accepted, waiting for start
    // S_ISSUE | one (i, w) pair per cycle fed to the D lanes
    // S_DRAIN | down-counter lets in-flight lane products land in C
    // S_DONE  | done pulse, busy low, back to idle next cycle
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    function automatic logic [2*M-2:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] r;
        r = '0;
        for (int n = 0; n < M; n++) begin
            if (b[n]) r = r ^ ({{(M-1){1'b0}}, a} << n);
        end
        return r;
    endfunction

    // Fold from the top down: x^k = x^(k-M+K) + x^(k-M) for k >= M.
    function automatic logic [M-1:0] gf_reduce(input logic [2*M-2:0] p);
        logic [2*M-2:0] r;
        r = p;
        for (int k = 2*M-2; k >= M; k--) begin
            if (r[k]) begin
                r[k-M]   = ~r[k-M];
                r[k-M+K] = ~r[k-M+K];
            end
        end
        return r[M-1:0];
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [WW-1:0] w_q, w_d;
    logic [1:0]    drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [M-1:0]  a_q [N];
    logic [M-1:0]  a_d [N];
    logic [M-1:0]  b_q [N];
    logic [M-1:0]  b_d [N];
    logic [M-1:0]  c_q [N];
    logic [M-1:0]  c_d [N];

    logic [M-1:0]  a_sel;
    logic [M-1:0]  lane_prod [D];
    logic [AW-1:0] lane_idx  [D];
    logic          lane_vld  [D];

    assign a_sel = a_q[i_q];

    for (genvar l = 0; l < D; l++) begin : g_lane
        logic [JW-1:0] j;
        logic [JW-1:0] sum;
        logic          hit;
        logic [M-1:0]  b_sel;
        logic [AW-1:0] tgt;
        logic [M-1:0]  prod_q, prod_d;
        logic [AW-1:0] tgt_q, tgt_d;
        logic          vld_q, vld_d;

        always_comb begin
            j     = JW'(w_q) * JW'(D) + JW'(l);
            hit   = (state_q == S_ISSUE) && (j < N_J);
            b_sel = hit ? b_q[j[AW-1:0]] : '0;
            sum   = JW'(i_q) + j;
            tgt   = (sum >= N_J) ? AW'(sum - N_J) : AW'(sum);
        end

`ifdef GF2MZ_PIPE_EN
        logic [2*M-2:0] raw_q, raw_d;
        logic [AW-1:0]  tgt1_q, tgt1_d;
        logic           vld1_q, vld1_d;

        always_comb begin
            raw_d  = clmul(a_sel, b_sel);
            tgt1_d = tgt;
            vld1_d = hit;
            prod_d = gf_reduce(raw_q);
            tgt_d  = tgt1_q;
            vld_d  = vld1_q;
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                raw_q  <= '0;
                tgt1_q <= '0;
                vld1_q <= 1'b0;
            end else begin
                raw_q  <= raw_d;
                tgt1_q <= tgt1_d;
                vld1_q <= vld1_d;
            end
        end
`else
        always_comb begin
            prod_d = gf_reduce(clmul(a_sel, b_sel));
            tgt_d  = tgt;
            vld_d  = hit;
        end
`endif

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                prod_q <= '0;
                tgt_q  <= '0;
                vld_q  <= 1'b0;
            end else begin
                prod_q <= prod_d;
                tgt_q  <= tgt_d;
                vld_q  <= vld_d;
            end
        end

        assign lane_prod[l] = prod_q;
        assign lane_idx[l]  = tgt_q;
        assign lane_vld[l]  = vld_q;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        w_d     = w_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = done_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;

        // Lane targets within a cycle are distinct, so the XORs never collide.
        for (int l = 0; l < D; l++) begin
            if (lane_vld[l]) c_d[lane_idx[l]] = c_d[lane_idx[l]] ^ lane_prod[l];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.ld_we && ({1'b0, bus.ld_addr} < N_EXT)) begin
                    if (bus.ld_sel) b_d[bus.ld_addr] = bus.ld_data;
                    else            a_d[bus.ld_addr] = bus.ld_data;
                end
                if (bus.start) begin
                    c_d     = '{default: '0};
                    i_d     = '0;
                    w_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_q == W_LAST) begin
                    w_d = '0;
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        drain_d = DRAIN_LOAD;
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            w_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            c_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            w_q     <= w_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    assign bus.rd_data = ({1'b0, bus.rd_addr} < N_EXT) ? c_q[bus.rd_addr] : '0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_gf2mz_cyclic_mul.sv
// Bench for gf2mz_cyclic_mul: four instances (D = 5, 1, 4, N) share one stimulus stream,
// each gated by en[], and are compared against a shift-and-add GF(2^M) cyclic product model.
module tb_gf2mz_cyclic_mul;
    localparam int N  = 47;
    localparam int M  = 79;
    localparam int K  = 9;
    localparam int NI = 4;
    localparam int AW = $clog2(N);
`ifdef GF2MZ_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam logic [M-1:0] ONE      = 1;
    localparam logic [M-1:0] POLY_LOW = (ONE << K) | ONE;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_s   = 1'b0;
    logic          ld_we_s   = 1'b0;
    logic          ld_sel_s  = 1'b0;
    logic [AW-1:0] ld_addr_s = '0;
    logic [M-1:0]  ld_data_s = '0;
    logic [AW-1:0] rd_addr_s = '0;
    logic [NI-1:0] en        = '1;

    logic [M-1:0] rd_data_a [NI];
    logic         busy_a    [NI];
    logic         done_a    [NI];

    function automatic int d_of(input int g);
        case (g)
            0:       return 5;
            1:       return 1;
            2:       return 4;
            default: return N;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DG = (g == 0) ? 5 : (g == 1) ? 1 : (g == 2) ? 4 : N;
        gf2mz_cyclic_mul_if #(.N(N), .M(M)) ifc ();
        assign ifc.start   = start_s & en[g];
        assign ifc.ld_we   = ld_we_s & en[g];
        assign ifc.ld_sel  = ld_sel_s;
        assign ifc.ld_addr = ld_addr_s;
        assign ifc.ld_data = ld_data_s;
        assign ifc.rd_addr = rd_addr_s;
        assign rd_data_a[g] = ifc.rd_data;
        assign busy_a[g]    = ifc.busy;
        assign done_a[g]    = ifc.done;
        gf2mz_cyclic_mul #(.N(N), .M(M), .K(K), .D(DG)) u_dut (
            .clk   (clk),
            .rst_b (rst_b),
            .bus   (ifc)
        );
    end

    typedef struct {
        int           ai;
        logic [M-1:0] a;
        int           bj;
        logic [M-1:0] b;
        int           ci;
        logic [M-1:0] c;
    } vec_t;
    vec_t vt [6];

    logic [M-1:0] ta    [N];
    logic [M-1:0] tbv   [N];
    logic [M-1:0] exp_c [N];
    int tests = 0;
    int fails = 0;
    int lat [NI];

    function automatic logic [M-1:0] rnd_coef();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    // Shift-and-add field multiply: multiply-by-x with immediate reduction each step.
    function automatic logic [M-1:0] gf_mul_ref(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] s;
        r = '0;
        s = a;
        for (int n = 0; n < M; n++) begin
            if (b[n]) r = r ^ s;
            s = s[M-1] ? ((s << 1) ^ POLY_LOW) : (s << 1);
        end
        return r;
    endfunction

    task automatic model();
        for (int k = 0; k < N; k++) begin
            logic [M-1:0] c;
            c = '0;
            for (int i = 0; i < N; i++) c = c ^ gf_mul_ref(ta[i], tbv[(k - i + N) % N]);
            exp_c[k] = c;
        end
    endtask

    function automatic int exp_lat(input int g);
        return N * ((N + d_of(g) - 1) / d_of(g)) + L + 1;
    endfunction

    task automatic check_int(input string name, input int g, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s D=%0d: got %0d expected %0d", name, d_of(g), act, exp);
        end
    endtask

    task automatic check_c(input int g, input string name);
        int bad;
        logic [M-1:0] gotv;
        logic [M-1:0] expv;
        bad = -1;
        gotv = '0;
        expv = '0;
        for (int k = 0; k < N; k++) begin
            rd_addr_s = AW'(k);
            #1;
            if (bad < 0 && rd_data_a[g] !== exp_c[k]) begin
                bad  = k;
                gotv = rd_data_a[g];
                expv = exp_c[k];
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s D=%0d: C[%0d] got %h expected %h", name, d_of(g), bad, gotv, expv);
        end
    endtask

    task automatic check_all_c(input string name);
        for (int g = 0; g < NI; g++) if (en[g]) check_c(g, name);
    endtask

    task automatic load_one(input logic sel, input int addr, input logic [M-1:0] data);
        @(negedge clk);
        ld_we_s   = 1'b1;
        ld_sel_s  = sel;
        ld_addr_s = AW'(addr);
        ld_data_s = data;
        @(negedge clk);
        ld_we_s   = 1'b0;
    endtask

    task automatic load_ops();
        for (int a = 0; a < N; a++) load_one(1'b0, a, ta[a]);
        for (int b = 0; b < N; b++) load_one(1'b1, b, tbv[b]);
    endtask

    task automatic load_oob();
        for (int a = N; a < (1 << AW); a++) begin
            load_one(1'b0, a, rnd_coef());
            load_one(1'b1, a, rnd_coef());
        end
    endtask

    task automatic pulse_start(output int accept);
        @(negedge clk);
        start_s = 1'b1;
        accept  = cyc + 1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic wait_done(input int accept, input string name);
        logic [NI-1:0] seen;
        int cnt [NI];
        int bsy [NI];
        seen = '0;
        for (int g = 0; g < NI; g++) begin
            cnt[g] = 0;
            bsy[g] = 0;
        end
        for (int t = 0; t < 4000 && seen != en; t++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (en[g] && done_a[g]) begin
                    cnt[g]++;
                    if (!seen[g]) begin
                        seen[g] = 1'b1;
                        lat[g]  = cyc - accept;
                        bsy[g]  = int'(busy_a[g]);
                    end
                end
            end
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) if (en[g] && done_a[g]) cnt[g]++;
        for (int g = 0; g < NI; g++) begin
            if (en[g]) begin
                if (!seen[g]) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_done D=%0d: no done pulse within 4000 cycles", name, d_of(g));
                end else begin
                    check_int({name, "_latency"}, g, lat[g], exp_lat(g));
                    check_int({name, "_done_width"}, g, cnt[g], 1);
                    check_int({name, "_busy_at_done"}, g, bsy[g], 0);
                end
            end
        end
    endtask

    task automatic run_all(input string name);
        int acc;
        model();
        load_ops();
        pulse_start(acc);
        wait_done(acc, name);
        check_all_c(name);
    endtask

    task automatic clear_ops();
        for (int k = 0; k < N; k++) begin
            ta[k]  = '0;
            tbv[k] = '0;
        end
    endtask

    initial begin
        int acc;
        int acc2;

        vt[0] = '{ai: 0,  a: ONE << 1,  bj: 0,  b: ONE << 78, ci: 0,  c: M'('h201)};
        vt[1] = '{ai: 1,  a: ONE,       bj: 46, b: M'(5),     ci: 0,  c: M'(5)};
        vt[2] = '{ai: 46, a: ONE << 40, bj: 46, b: ONE << 40, ci: 45, c: M'('h402)};
        vt[3] = '{ai: 10, a: M'(3),     bj: 20, b: M'(3),     ci: 30, c: M'(5)};
        vt[4] = '{ai: 0,  a: ONE << 78, bj: 5,  b: ONE << 78, ci: 5,
                  c: (ONE << 77) | (ONE << 16) | (ONE << 7)};
        vt[5] = '{ai: 30, a: ONE << 78, bj: 40, b: ONE << 1,  ci: 23, c: M'('h201)};

        #2 rst_b = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check_int("reset_busy", g, int'(busy_a[g]), 0);
            check_int("reset_done", g, int'(done_a[g]), 0);
        end
        for (int k = 0; k < N; k++) exp_c[k] = '0;
        check_all_c("reset_c");
        repeat (3) @(negedge clk);
        rst_b = 1'b1;

        // Single-term products: field reduction and cyclic index wrap.
        for (int v = 0; v < 6; v++) begin
            clear_ops();
            ta[vt[v].ai]  = vt[v].a;
            tbv[vt[v].bj] = vt[v].b;
            load_ops();
            for (int k = 0; k < N; k++) exp_c[k] = '0;
            exp_c[vt[v].ci] = vt[v].c;
            pulse_start(acc);
            wait_done(acc, $sformatf("vec%0d", v));
            check_all_c($sformatf("vec%0d", v));
        end

        // A = 1 gives C = B.
        clear_ops();
        ta[0] = ONE;
        for (int k = 0; k < N; k++) tbv[k] = rnd_coef();
        load_ops();
        for (int k = 0; k < N; k++) exp_c[k] = tbv[k];
        pulse_start(acc);
        wait_done(acc, "a_one");
        check_all_c("a_one");
        rd_addr_s = AW'(50);
        #1;
        tests++;
        if (rd_data_a[0] !== '0) begin
            fails++;
            $display("FAIL rd_oob: got %h expected 0", rd_data_a[0]);
        end

        // A = z rotates B by one coefficient.
        clear_ops();
        ta[1] = ONE;
        for (int k = 0; k < N; k++) tbv[k] = M'(k + 1);
        load_ops();
        exp_c[0] = M'(N);
        for (int k = 1; k < N; k++) exp_c[k] = M'(k);
        pulse_start(acc);
        wait_done(acc, "a_z");
        check_all_c("a_z");

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                ta[k]  = rnd_coef();
                tbv[k] = rnd_coef();
            end
            model();
            load_ops();
            load_oob();
            pulse_start(acc);
            wait_done(acc, $sformatf("rand%0d", r));
            check_all_c($sformatf("rand%0d", r));
        end

        // start and ld_we pulsed mid-run must be ignored.
        en = 4'b0001;
        for (int k = 0; k < N; k++) begin
            ta[k]  = rnd_coef();
            tbv[k] = rnd_coef();
        end
        model();
        load_ops();
        pulse_start(acc);
        for (int t = 0; t < 200 && cyc < acc + 100; t++) @(negedge clk);
        check_int("busy_mid", 0, int'(busy_a[0]), 1);
        start_s   = 1'b1;
        ld_we_s   = 1'b1;
        ld_sel_s  = 1'b0;
        ld_addr_s = '0;
        ld_data_s = '1;
        @(negedge clk);
        start_s = 1'b0;
        ld_we_s = 1'b0;
        wait_done(acc, "inject");
        check_c(0, "inject");

        // start held through the done cycle is taken only on the following edge.
        pulse_start(acc);
        acc2 = 0;
        for (int t = 0; t < 4000 && !done_a[0]; t++) @(negedge clk);
        tests++;
        if (!done_a[0]) begin
            fails++;
            $display("FAIL b2b_first_done: no done pulse within 4000 cycles");
        end
        start_s = 1'b1;
        acc2 = cyc + 2;
        @(negedge clk);
        @(negedge clk);
        start_s = 1'b0;
        wait_done(acc2, "b2b");
        check_c(0, "b2b");

        // Asynchronous reset mid-run.
        en = '1;
        for (int k = 0; k < N; k++) begin
            ta[k]  = rnd_coef();
            tbv[k] = rnd_coef();
        end
        load_ops();
        pulse_start(acc);
        for (int t = 0; t < 300 && cyc < acc + 200; t++) @(negedge clk);
        rst_b = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check_int("rst_mid_busy", g, int'(busy_a[g]), 0);
            check_int("rst_mid_done", g, int'(done_a[g]), 0);
        end
        for (int k = 0; k < N; k++) exp_c[k] = '0;
        check_all_c("rst_mid_c");
        @(negedge clk);
        rst_b = 1'b1;

        // Only B[0] = 1 loaded: a cleared A must give C = 0.
        load_one(1'b1, 0, ONE);
        for (int k = 0; k < N; k++) exp_c[k] = '0;
        pulse_start(acc);
        wait_done(acc, "rst_a_clear");
        check_all_c("rst_a_clear");

        for (int k = 0; k < N; k++) begin
            ta[k]  = rnd_coef();
            tbv[k] = rnd_coef();
        end
        run_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish within 3000000 time units");
        $fatal(1);
    end
endmodule

// File: doc/gf2mz_cyclic_mul.md
Name: gf2mz_cyclic_mul

Overview:
Parametrised successor to the fixed 5x5 GF(2^m)[z] multiplier top. Computes C(z) = A(z)·B(z) mod (z^N − 1) over GF(2^M), with field polynomial x^M + x^K + 1. It uses D parallel GF(2^M) multiplier lanes built with generate loops, so lane count is a parameter rather than hand-instanced.
Operands and result are held in internal register files, loaded and read coefficient-serially. The block sits under the ROLLO encrypt datapath as the polynomial-product engine.

Parameters:
N, 47, polynomial length (number of coefficients).
M, 79, field degree; each coefficient is M bits.
K, 9, middle term of the trinomial x^M + x^K + 1; 0 < K < M.
D, 5, number of parallel multiplier lanes (coefficients of B consumed per cycle); 1 ≤ D ≤ N.

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
start  in  1  begin multiplication; sampled only when idle
ld_we  in  1  operand load strobe
ld_sel  in  1  0 = load A, 1 = load B
ld_addr  in  CLOG2(N)  coefficient index to load
ld_data  in  M  coefficient value
rd_addr  in  CLOG2(N)  result coefficient index
rd_data  out  M  C[rd_addr], combinational from the result register file
busy  out  1  high while computing
done  out  1  one-cycle pulse when C is final

Behaviour:
- Clock and reset: one clock, clk. Reset rst_b is asynchronous and active-low.
- Reset values: busy=0, done=0. A, B and C register files cleared to 0. FSM in IDLE; counters i and w at 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ld_we with ld_addr < N writes ld_data to A[ld_addr] or B[ld_addr] on the clock edge.
  - ld_addr ≥ N is ignored.
  - start=1 clears C, sets i=0, w=0, busy=1, and moves to ISSUE.
- ISSUE, one cycle per (i, w):
  - W = ceil(N/D).
  - Lane l handles j = w·D + l. If j < N, it multiplies a = A[i] by B[j].
  - Lanes with j ≥ N are masked (product forced to 0, no write).
  - w increments. At w = W−1, w wraps to 0 and i increments.
  - After i = N−1, w = W−1, go to DRAIN.
  - Issue cycles total N·W (470 at defaults).
- Multiplier lane: full GF(2^M) product, reduced by x^M = x^K + 1. Output registered: latency L = 1, or L = 2 with GF2MZ_PIPE_EN.
- Accumulate: a lane result for (i, j) XORs into C[(i + j) mod N] on the edge its product is valid.
  - Targets within one cycle are distinct, since j values are distinct and less than N. No write conflicts.
  - Accumulation is a read-modify-write of the register in the same cycle, so there is no pipeline hazard.
  - The index/valid tag travels with the product through the L pipeline stages.
- DRAIN: waits L cycles for in-flight products, then goes to DONE.
- DONE: done=1 for exactly one cycle and busy=0, then return to IDLE.
  - done rises N·W + L + 1 edges after the edge that accepted start.
- start while busy: ignored. ld_we while busy: ignored, and A/B stay unchanged.
- rd_data:
  - Valid only when busy=0. During busy it shows a partial value.
  - rd_addr ≥ N returns 0.
- Back-to-back: start in the same cycle done is high is ignored (the FSM is not yet IDLE). start is accepted in the next cycle.
- rst_b asserted mid-operation: immediate return to reset values. Operands are lost and no done pulse is issued.
- All arithmetic is XOR in GF(2). Index (i + j) mod N is computed as i + j − N when i + j ≥ N; i + j < 2N always.

Optional Feature:
GF2MZ_PIPE_EN:
- Defined: each lane has an extra register splitting the partial product from the reduction, so L = 2. done is delayed by one cycle; results are identical.
- Undefined: single-stage lane, L = 1.

Test Plan:
- A = 1 (A[0]=1, others 0), B random, start → after done, C[j] = B[j] for all j; done exactly N·W+L+1 = 472 edges after start (L=1).
- A = z (A[1]=1), B[j] = j+1 → C[0] = 47, C[j] = j for j ≥ 1 (cyclic rotation wrap).
- Field reduction: A[0] = 2 (x), B[0] = 1<<78, others 0 → C[0] = 0x201 (x^9 + 1), all other C = 0.
- Random A, B at defaults plus D=1, D=4 (N%D ≠ 0, masked lanes) and D=N → C matches a software model mod (z^47 − 1); cycle count scales as N·ceil(N/D).
- Pulse start and ld_we (A[0] = all ones) at cycle 100 of a run → both ignored; result equals the run without them.
- rst_b low at cycle 200 of a run → busy=0 and done=0 at once; A, B, C read 0; a new load and start completes correctly.
